game_ctrl: RTL and testbench
============================

# game_ctrl

Central game controller for the 4-digit guessing game. It sits directly upstream of `display_ctrl` and drives that block's `state`, `blink_on`, `target`, `guess`, `candidate`, `sw_valid`, `chances` and `is_random` inputs. It sequences secret entry (manual or random per digit), up to five guess rounds, and the win/lose outcome. Inputs are the slide switches and two single-cycle button pulses.

## Interface
- `BLINK_DIV`, default 25_000_000: clock cycles per `blink_on` half-period.
- `MAX_CHANCES`, default 5: guesses per game; must be ≤ 7.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `sw`  in  4  digit candidate from the switches.
- `confirm`  in  1  one-cycle pulse, already debounced and edge-detected.
- `random`  in  1  one-cycle pulse; requests a random digit in the SET states.
- `state`  out  state_t  current state (game_types enumeration).
- `blink_on`  out  1  free-running blink square wave.
- `target`  out  4×4  secret digits; index 3 is the leftmost digit.
- `guess`  out  4×4  current guess digits.
- `candidate`  out  4  equals `sw` (combinational).
- `sw_valid`  out  1  `sw` is acceptable for the current position (combinational).
- `chances`  out  3  remaining guesses.
- `is_random`  out  4  per-digit flag: the target digit was randomly generated.

## Operation
- Digit validity. `sw_valid` is 1 when both hold:
  - `sw` ≤ 9.
  - `sw` differs from every already-committed digit of the current entry:
    - SET_Dn: `target[3..n+1]`.
    - GUESS_Dn: `guess[3..n+1]`.
  - In all other states, `sw_valid` = 0.
- S_IDLE: `confirm` → S_SET_D3. Clear `target`, `guess` and `is_random` to 0. Load `chances` = MAX_CHANCES.
- S_SET_Dn (n = 3..0):
  - `confirm` & `sw_valid`: `target[n]` ← `sw`, `is_random[n]` ← 0, advance.
  - `random`: `target[n]` ← the random digit (rules below), `is_random[n]` ← 1, advance.
  - `confirm` & !`sw_valid`: no change.
  - `confirm` and `random` in the same cycle: `confirm` wins; if `sw` is invalid, nothing happens.
  - Advance order: D3 → D2 → D1 → D0 → S_GUESS_D3.
- Random digit generation:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Seed 8'h01 at reset. Steps every cycle, in every state.
  - Raw digit r = `lfsr` mod 10.
  - While r collides with `target[3..n+1]`, r ← (r+1) mod 10. At most 3 steps; resolved combinationally within the same cycle.
- S_GUESS_Dn:
  - `confirm` & `sw_valid`: `guess[n]` ← `sw`, advance. `random` is ignored.
  - Commit in D0 → S_SHOW_RESULT. In the same edge, `chances` ← `chances` − 1.
- S_SHOW_RESULT: on `confirm`:
  - `guess` == `target` (all 4 digits) → S_WIN.
  - else `chances` == 0 → S_LOSE.
  - else → S_GUESS_D3. `guess` is retained; positions not yet re-entered are masked downstream.
- S_WIN / S_LOSE: `confirm` → S_IDLE.
- Blink generator:
  - Counter runs 0..BLINK_DIV−1.
  - `blink_on` toggles when the counter wraps.
  - Runs independently of state and is never reset by state changes.

## Timing
- All state, `target`, `guess`, `chances`, `is_random`, `lfsr` and blink registers update on the `clk` rising edge.
- `candidate` and `sw_valid` are combinational from `sw`, `state` and the committed digits. They have zero latency.
- A `confirm` or `random` pulse sampled in cycle k produces the new state and data at the edge ending cycle k. The outputs are visible in cycle k+1.
- Exactly one transition per pulse. A pulse lasting more than one cycle is out of contract.
- Reset (asynchronous, any state, any cycle), immediately:
  - `state` = S_IDLE
  - `target` = `guess` = {0,0,0,0}
  - `is_random` = 0
  - `chances` = 0
  - `lfsr` = 8'h01
  - blink counter = 0, `blink_on` = 0
- Deassertion is synchronous to `clk` by the board reset conditioner. The block resumes in S_IDLE on the first edge after deassertion.
- `chances` never underflows. It only decrements on a D0 commit, and a commit can only occur with `chances` ≥ 1.

## Test plan
- Manual secret, then win:
  - Stimulus: reset, `confirm`; enter 1,2,3,4 with `confirm` each; guess 1,2,3,4; `confirm` in S_SHOW_RESULT.
  - Required: `target` = {1,2,3,4}, `is_random` = 0000, `chances` = 4 in S_SHOW_RESULT, then S_WIN; `confirm` → S_IDLE.
- Validity checks:
  - Stimulus: in S_SET_D2 with `target[3]` = 7, drive `sw` = 7, then 4'hA, then 3.
  - Required: `sw_valid` = 0, 0, 1. A `confirm` while invalid leaves the state at S_SET_D2.
- Random digits:
  - Stimulus: press `random` at all four SET states.
  - Required: `is_random` = 1111; all target digits ≤ 9 and pairwise distinct; values match a reference LFSR model seeded 8'h01.
- Lose path:
  - Stimulus: target {1,2,3,4}; five wrong guesses {5,6,7,8}.
  - Required: `chances` goes 5 → 4 → 3 → 2 → 1 → 0; after the fifth S_SHOW_RESULT, `confirm` → S_LOSE.
- Simultaneous pulses and asynchronous reset:
  - Stimulus: `confirm` + `random` together with `sw` = 9 valid; then assert `rst` mid-guess with no clock edge.
  - Required: `target[n]` = 9 with `is_random[n]` = 0; on `rst`, outputs take their reset values immediately, before any edge.
- Blink:
  - Stimulus: BLINK_DIV = 4.
  - Required: `blink_on` toggles every 4 cycles after reset (0 for cycles 0–3, 1 for cycles 4–7), unaffected by state transitions.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: sequences secret entry, guess rounds and win/lose outcome for the 4-digit guessing game
package game_types;
  typedef enum logic [3:0] {
    S_IDLE, S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0,
    S_GUESS_D3, S_GUESS_D2, S_GUESS_D1, S_GUESS_D0,
    S_SHOW_RESULT, S_WIN, S_LOSE
  } state_t;
endpackage

module game_ctrl import game_types::*; #(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int MAX_CHANCES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      sw,
  input  logic            confirm,
  input  logic            random,
  output state_t          state,
  output logic            blink_on,
  output logic [3:0][3:0] target,
  output logic [3:0][3:0] guess,
  output logic [3:0]      candidate,
  output logic            sw_valid,
  output logic [2:0]      chances,
  output logic [3:0]      is_random
);
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  state_t next;
  logic [7:0] lfsr, lmod;
  logic [CW-1:0] cnt;
  logic [3:0] st1, mask, rnd;
  logic [1:0] pos;
  logic is_set, is_guess, set_sw, set_rnd, guess_sw;

  function automatic logic hit(input logic [3:0][3:0] d, input logic [3:0] m, input logic [3:0] v);
    return (m[3] && d[3] == v) || (m[2] && d[2] == v) || (m[1] && d[1] == v);
  endfunction

  // SET and GUESS states are laid out D3..D0, so the digit position is the inverted low bits of state-1
  always_comb begin
    st1 = state - 4'd1;
    pos = ~st1[1:0];
    mask = {pos < 2'd3, pos < 2'd2, pos < 2'd1, 1'b0};
    is_set = state inside {[S_SET_D3:S_SET_D0]};
    is_guess = state inside {[S_GUESS_D3:S_GUESS_D0]};
    sw_valid = (is_set || is_guess) && sw <= 4'd9 && !hit(is_set ? target : guess, mask, sw);
    set_sw = is_set && confirm && sw_valid;
    set_rnd = is_set && random && !confirm;
    guess_sw = is_guess && confirm && sw_valid;
    lmod = lfsr % 8'd10;
    rnd = lmod[3:0];
    for (int i = 0; i < 3; i++) rnd = hit(target, mask, rnd) ? (rnd == 4'd9 ? 4'd0 : rnd + 4'd1) : rnd;
  end

  assign candidate = sw;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      S_IDLE:        if (confirm) next = S_SET_D3;
      S_SHOW_RESULT: if (confirm) next = guess == target ? S_WIN : chances == 3'd0 ? S_LOSE : S_GUESS_D3;
      S_WIN, S_LOSE: if (confirm) next = S_IDLE;
      default:       if (set_sw || set_rnd || guess_sw) next = state_t'(state + 4'd1);
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target <= '0;
      guess <= '0;
      is_random <= '0;
      chances <= '0;
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == S_IDLE && confirm) begin
        target <= '0;
        guess <= '0;
        is_random <= '0;
        chances <= 3'(MAX_CHANCES);
      end
      if (set_sw || set_rnd) begin
        target[pos] <= set_sw ? sw : rnd;
        is_random[pos] <= set_rnd;
      end
      if (guess_sw) begin
        guess[pos] <= sw;
        if (pos == 2'd0) chances <= chances - 3'd1;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      blink_on <= 1'b0;
    end else begin
      cnt <= cnt == CW'(BLINK_DIV - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(BLINK_DIV - 1)) blink_on <= ~blink_on;
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: table-driven and sequence checks for game_ctrl with a random-digit scoreboard
module tb_game_ctrl;
  import game_types::*;
  logic clk = 0, rst = 1, confirm = 0, random = 0;
  logic [3:0] sw = 0;
  state_t state;
  logic blink_on, sw_valid;
  logic [3:0][3:0] target, guess;
  logic [3:0] candidate, is_random;
  logic [2:0] chances;
  logic [7:0] m_lfsr;
  logic [3:0] q[$];
  logic [3:0] tm [4];
  int checks = 0, errors = 0;

  typedef struct {logic c; logic r; logic [3:0] s; state_t st; logic [2:0] ch;} vec_t;
  typedef struct {logic [3:0] s; logic v;} vv_t;
  vec_t win_tab [13];
  vv_t val_tab [6];

  game_ctrl #(.BLINK_DIV(4), .MAX_CHANCES(5)) dut (
    .clk(clk), .rst(rst), .sw(sw), .confirm(confirm), .random(random),
    .state(state), .blink_on(blink_on), .target(target), .guess(guess),
    .candidate(candidate), .sw_valid(sw_valid), .chances(chances), .is_random(is_random)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 8'h01;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic c, input logic r, input logic [3:0] s);
    sw = s;
    confirm = c;
    random = r;
    @(posedge clk);
    #1;
    confirm = 0;
    random = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic enter4(input logic [15:0] d);
    for (int i = 3; i >= 0; i--) pulse(1'b1, 1'b0, d[i*4 +: 4]);
  endtask

  // search upward from lfsr%10 until no committed digit is hit
  function automatic logic [3:0] model_rnd(input logic [7:0] l, input logic [3:0] d [4], input int n);
    int r = int'(l) % 10;
    bit col;
    for (int k = 0; k < 10; k++) begin
      col = 0;
      for (int i = n + 1; i < 4; i++) if (int'(d[i]) == r) col = 1;
      if (!col) break;
      r = (r + 1) % 10;
    end
    return 4'(r);
  endfunction

  initial begin
    win_tab = '{
      '{1'b1, 1'b0, 4'd0, S_SET_D3,      3'd5},
      '{1'b1, 1'b0, 4'd1, S_SET_D2,      3'd5},
      '{1'b1, 1'b0, 4'd2, S_SET_D1,      3'd5},
      '{1'b1, 1'b0, 4'd3, S_SET_D0,      3'd5},
      '{1'b1, 1'b0, 4'd4, S_GUESS_D3,    3'd5},
      '{1'b1, 1'b0, 4'd1, S_GUESS_D2,    3'd5},
      '{1'b1, 1'b0, 4'd1, S_GUESS_D2,    3'd5},
      '{1'b0, 1'b1, 4'd0, S_GUESS_D2,    3'd5},
      '{1'b1, 1'b0, 4'd2, S_GUESS_D1,    3'd5},
      '{1'b1, 1'b0, 4'd3, S_GUESS_D0,    3'd5},
      '{1'b1, 1'b0, 4'd4, S_SHOW_RESULT, 3'd4},
      '{1'b1, 1'b0, 4'd0, S_WIN,         3'd4},
      '{1'b1, 1'b0, 4'd0, S_IDLE,        3'd4}
    };
    val_tab = '{'{4'd7, 1'b0}, '{4'hA, 1'b0}, '{4'd3, 1'b1}, '{4'd9, 1'b1}, '{4'hF, 1'b0}, '{4'd0, 1'b1}};

    do_reset;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_chances", 32'(chances), 0);
    chk("rst_target", 32'(target), 0);
    chk("rst_valid", 32'(sw_valid), 0);
    chk("blink_0", 32'(blink_on), 0);
    for (int k = 1; k < 8; k++) begin
      if (k == 3) pulse(1'b1, 1'b0, 4'd0);
      else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("blink_%0d", k), 32'(blink_on), k >= 4 ? 1 : 0);
    end
    chk("blink_state", 32'(state), 32'(S_SET_D3));

    do_reset;
    for (int i = 0; i < 13; i++) begin
      pulse(win_tab[i].c, win_tab[i].r, win_tab[i].s);
      chk($sformatf("win_state_%0d", i), 32'(state), 32'(win_tab[i].st));
      chk($sformatf("win_chances_%0d", i), 32'(chances), 32'(win_tab[i].ch));
    end
    chk("win_target", 32'(target), 32'h1234);
    chk("win_guess", 32'(guess), 32'h1234);
    chk("win_is_random", 32'(is_random), 0);

    pulse(1'b1, 1'b0, 4'd0);
    pulse(1'b1, 1'b0, 4'd7);
    for (int i = 0; i < 6; i++) begin
      sw = val_tab[i].s;
      #1;
      chk($sformatf("valid_%0h", val_tab[i].s), 32'(sw_valid), 32'(val_tab[i].v));
      chk($sformatf("cand_%0h", val_tab[i].s), 32'(candidate), 32'(val_tab[i].s));
    end
    pulse(1'b1, 1'b0, 4'd7);
    chk("inval_dup_state", 32'(state), 32'(S_SET_D2));
    pulse(1'b1, 1'b0, 4'hA);
    chk("inval_a_state", 32'(state), 32'(S_SET_D2));
    pulse(1'b1, 1'b1, 4'd9);
    chk("both_state", 32'(state), 32'(S_SET_D1));
    chk("both_digit", 32'(target[2]), 9);
    chk("both_is_random", 32'(is_random), 0);
    pulse(1'b1, 1'b1, 4'd9);
    chk("both_inval_state", 32'(state), 32'(S_SET_D1));
    chk("both_inval_target", 32'(target), 32'h7900);

    do_reset;
    pulse(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) tm[i] = 0;
    for (int n = 3; n >= 0; n--) begin
      tm[n] = model_rnd(m_lfsr, tm, n);
      q.push_back(tm[n]);
      pulse(1'b0, 1'b1, 4'd0);
    end
    chk("rnd_state", 32'(state), 32'(S_GUESS_D3));
    chk("rnd_is_random", 32'(is_random), 32'hF);
    for (int n = 3; n >= 0; n--) begin
      logic [3:0] e;
      e = q.pop_front();
      chk($sformatf("rnd_digit_%0d", n), 32'(target[n]), 32'(e));
      chk($sformatf("rnd_le9_%0d", n), 32'(target[n] <= 4'd9), 1);
    end
    begin
      int dup = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++) if (target[i] == target[j]) dup++;
      chk("rnd_distinct", 32'(dup), 0);
    end

    do_reset;
    pulse(1'b1, 1'b0, 4'd0);
    enter4(16'h1234);
    chk("lose_chances_start", 32'(chances), 5);
    for (int r = 0; r < 5; r++) begin
      enter4(16'h5678);
      chk($sformatf("lose_show_%0d", r), 32'(state), 32'(S_SHOW_RESULT));
      chk($sformatf("lose_chances_%0d", r), 32'(chances), 32'(4 - r));
      pulse(1'b1, 1'b0, 4'd0);
      chk($sformatf("lose_next_%0d", r), 32'(state), r < 4 ? 32'(S_GUESS_D3) : 32'(S_LOSE));
      if (r == 0) chk("lose_guess_kept", 32'(guess), 32'h5678);
    end
    pulse(1'b1, 1'b0, 4'd0);
    chk("lose_idle", 32'(state), 32'(S_IDLE));

    do_reset;
    pulse(1'b1, 1'b0, 4'd0);
    enter4(16'h1234);
    pulse(1'b1, 1'b0, 4'd5);
    pulse(1'b1, 1'b0, 4'd6);
    chk("mid_state", 32'(state), 32'(S_GUESS_D1));
    #2;
    rst = 1;
    #1;
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_target", 32'(target), 0);
    chk("arst_guess", 32'(guess), 0);
    chk("arst_chances", 32'(chances), 0);
    chk("arst_is_random", 32'(is_random), 0);
    chk("arst_blink", 32'(blink_on), 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("arst_resume", 32'(state), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
